prg_loader: RTL and testbench

- Generalised PRG image loader that sits between the mist_io ioctl download stream and the machine's DMA write port.
- Strips the 2-byte load-address header and writes payload bytes at the correct CPU addresses, with a back-pressure handshake and a memory-window check.
- After the download it rewrites the BASIC end-of-program pointers so that RUN works without a manual LOAD.
- Instanced per target machine. The PET instance uses the defaults.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/prg_loader_dma_write_port.sv | 54 +++++
 rtl/prg_loader.sv | 205 ++++++++++++++++++++
 tb/tb_prg_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the PRG image loader.
package loader_pkg;

  // ioctl download stream widths
  localparam int IOCTL_AW = 25;
  localparam int IOCTL_DW = 8;

  // Bit positions inside the sticky error vector
  localparam int ERR_WIN   = 0;
  localparam int ERR_OVR   = 1;
  localparam int ERR_SHORT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WPEND,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/prg_loader_dma_write_port.sv
// Request/ack holding register for the DMA write port. A load captures
// address and data and raises we; we stays up, with address and data
// stable, until the ack. A load on the same cycle as an ack starts the
// next request immediately.
module dma_write_port #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        data_in,
  input  logic              ack,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_dout,
  output logic              dma_we
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;

  // Next request state: a new load wins over the ack of the current one
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    we_d   = we_q;
    if (load) begin
      addr_d = addr_in;
      data_d = data_in;
      we_d   = 1'b1;
    end else if (we_q && ack) begin
      we_d   = 1'b0;
    end
  end

  // Request register; reset drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign dma_addr = addr_q;
  assign dma_dout = data_q;
  assign dma_we   = we_q;

endmodule

// File: rtl/prg_loader.sv
// PRG image loader: strips the 2-byte load address, writes the payload
// through the DMA port inside the writable window, then rewrites the
// BASIC end-of-program pointers with the end address.
module prg_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [7:0]        INDEX      = 8'h41,
  parameter logic [ADDR_W-1:0] WIN_LO     = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] WIN_HI     = ADDR_W'(16'h3FFF),
  parameter int unsigned       FIXUP_N    = 3,
  parameter logic [ADDR_W-1:0] FIXUP_BASE = ADDR_W'(16'h002A)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [IOCTL_DW-1:0] ioctl_dout,
  output logic                ioctl_wait,
  output logic [ADDR_W-1:0]   dma_addr,
  output logic [7:0]          dma_dout,
  output logic                dma_we,
  input  logic                dma_ack,
  output logic [ADDR_W-1:0]   load_addr,
  output logic [ADDR_W-1:0]   end_addr,
  output logic                busy,
  output logic                done,
  output logic [2:0]          error
);

  localparam logic [7:0] FIX_CNT = 8'(2 * FIXUP_N);

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [7:0]        fix_idx_q, fix_idx_d;
  logic              endf_q, endf_d;   // download ended while a write was pending
  logic              acc_q, acc_d;     // at least one payload byte written
  logic              got_q, got_d;     // at least one payload byte received

  logic              sel, sel_rise;
  logic [ADDR_W-1:0] tgt_addr;
  logic              in_win;
  logic              wr_load;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  assign sel      = ioctl_download && (ioctl_index == INDEX);
  assign sel_rise = sel && !sel_q;
  assign tgt_addr = load_addr_q + ioctl_addr[ADDR_W-1:0] - ADDR_W'(2);
  // Single unsigned compare covers both window bounds
  assign in_win   = (tgt_addr - WIN_LO) <= (WIN_HI - WIN_LO);

  // Next-state, bookkeeping and write-request generation
  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    done_d      = done_q;
    err_d       = err_q;
    load_addr_d = load_addr_q;
    end_addr_d  = end_addr_q;
    fix_idx_d   = fix_idx_q;
    endf_d      = endf_q;
    acc_d       = acc_q;
    got_d       = got_q;
    wr_load     = 1'b0;
    wr_addr     = tgt_addr;
    wr_data     = ioctl_dout;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (sel_rise) begin
          state_d     = S_HDR;
          done_d      = 1'b0;
          err_d       = '0;
          load_addr_d = '0;
          end_addr_d  = '0;
          fix_idx_d   = '0;
          endf_d      = 1'b0;
          acc_d       = 1'b0;
          got_d       = 1'b0;
        end
      end
      S_HDR: begin
        if (!sel) begin
          err_d[ERR_SHORT] = 1'b1;
          done_d           = 1'b1;
          state_d          = S_DONE;
        end else if (ioctl_wr) begin
          if (ioctl_addr == IOCTL_AW'(0)) begin
            load_addr_d[7:0] = ioctl_dout;
          end else if (ioctl_addr == IOCTL_AW'(1)) begin
            load_addr_d[15:8] = ioctl_dout;
            state_d           = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (!sel) begin
          if (!got_q) err_d[ERR_SHORT] = 1'b1;
          if (acc_q && (FIXUP_N != 0)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else if (ioctl_wr && (ioctl_addr >= IOCTL_AW'(2))) begin
          got_d = 1'b1;
          if (in_win) begin
            wr_load    = 1'b1;
            end_addr_d = tgt_addr + ADDR_W'(1);
            acc_d      = 1'b1;
            state_d    = S_WPEND;
          end else begin
            err_d[ERR_WIN] = 1'b1;
          end
        end
      end
      S_WPEND: begin
        if (!sel) endf_d = 1'b1;
        if (sel && ioctl_wr) err_d[ERR_OVR] = 1'b1;
        if (dma_ack) begin
          if (endf_q || !sel) begin
            if (FIXUP_N != 0) begin
              state_d = S_FIX;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_FIX: begin
        wr_addr = FIXUP_BASE + ADDR_W'(fix_idx_q);
        wr_data = fix_idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
        if (!dma_we || dma_ack) begin
          if (fix_idx_q == FIX_CNT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            wr_load   = 1'b1;
            fix_idx_d = fix_idx_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      load_addr_q <= '0;
      end_addr_q  <= '0;
      fix_idx_q   <= '0;
      endf_q      <= 1'b0;
      acc_q       <= 1'b0;
      got_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_addr_q <= load_addr_d;
      end_addr_q  <= end_addr_d;
      fix_idx_q   <= fix_idx_d;
      endf_q      <= endf_d;
      acc_q       <= acc_d;
      got_q       <= got_d;
    end
  end

  dma_write_port #(
    .ADDR_W (ADDR_W)
  ) u_port (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_load),
    .addr_in  (wr_addr),
    .data_in  (wr_data),
    .ack      (dma_ack),
    .dma_addr (dma_addr),
    .dma_dout (dma_dout),
    .dma_we   (dma_we)
  );

  assign ioctl_wait = (state_q == S_WPEND);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = done_q;
  assign error      = err_q;
  assign load_addr  = load_addr_q;
  assign end_addr   = end_addr_q;

endmodule

// File: tb/tb_prg_loader.sv
// Bench for prg_loader: directed downloads, a DMA responder with
// programmable ack delay, and a scoreboard of expected DMA writes.
module tb_prg_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        dma_ack;
  logic [15:0] load_addr;
  logic [15:0] end_addr;
  logic        busy;
  logic        done;
  logic [2:0]  error;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  ack_delay = 0;
  int  wait_cycles, we_cycles, busy_cycles;

  prg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_addr       (dma_addr),
    .dma_dout       (dma_dout),
    .dma_we         (dma_we),
    .dma_ack        (dma_ack),
    .load_addr      (load_addr),
    .end_addr       (end_addr),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_fix(input logic [15:0] ea);
    for (int k = 0; k < 3; k++) begin
      expect_wr(16'h002A + 16'(2 * k), ea[7:0]);
      expect_wr(16'h002B + 16'(2 * k), ea[15:8]);
    end
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input int off, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 100) begin
      tick();
      guard++;
    end
    if (ioctl_wait) begin
      n_checks++;
      $display("FAIL wait_timeout: ioctl_wait still %0b at offset %0d, required 0", ioctl_wait, off);
    end
    ioctl_addr = 25'(off);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic force_byte(input int off, input logic [7:0] d);
    ioctl_addr = 25'(off);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 300) begin
      tick();
      guard++;
    end
    check("done", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_counts();
    wait_cycles = 0;
    we_cycles   = 0;
    busy_cycles = 0;
  endtask

  // DMA responder: acks a pending write after ack_delay waiting cycles
  initial begin
    int cnt = 0;
    dma_ack = 1'b0;
    forever begin
      tick();
      if (dma_ack) begin
        dma_ack = 1'b0;
        cnt     = 0;
      end else if (dma_we) begin
        if (cnt >= ack_delay) dma_ack = 1'b1;
        else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pop and compare each accepted write, count activity cycles
  always @(negedge clk) begin : monitor
    wr_t e;
    if (ioctl_wait) wait_cycles++;
    if (dma_we)     we_cycles++;
    if (busy)       busy_cycles++;
    if (!reset && dma_we && dma_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got %04h=%02h required none", dma_addr, dma_dout);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(dma_addr), 32'(e.addr));
        check("wr_data", 32'(dma_dout), 32'(e.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    clear_counts();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_dma_we", 32'(dma_we), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_load_addr", 32'(load_addr), 32'd0);
    check("rst_end_addr", 32'(end_addr), 32'd0);

    // Basic load
    ack_delay = 0;
    expect_wr(16'h0401, 8'hAA);
    expect_wr(16'h0402, 8'hBB);
    expect_wr(16'h0403, 8'hCC);
    expect_fix(16'h0404);
    start_load(8'h41);
    send_byte(0, 8'h01);
    send_byte(1, 8'h04);
    send_byte(2, 8'hAA);
    send_byte(3, 8'hBB);
    send_byte(4, 8'hCC);
    ioctl_download = 1'b0;
    wait_done();
    check("basic_error", 32'(error), 32'd0);
    check("basic_load_addr", 32'(load_addr), 32'h0401);
    check("basic_end_addr", 32'(end_addr), 32'h0404);

    // Back-pressure with a forced byte during a pending write
    ack_delay = 5;
    tick();
    clear_counts();
    expect_wr(16'h0401, 8'hAA);
    expect_wr(16'h0402, 8'hBB);
    expect_wr(16'h0403, 8'hCC);
    expect_fix(16'h0404);
    start_load(8'h41);
    send_byte(0, 8'h01);
    send_byte(1, 8'h04);
    send_byte(2, 8'hAA);
    force_byte(3, 8'h55);
    send_byte(3, 8'hBB);
    send_byte(4, 8'hCC);
    ioctl_download = 1'b0;
    wait_done();
    check("bp_error", 32'(error), 32'b010);
    check("bp_wait_cycles", 32'(wait_cycles), 32'd18);
    check("bp_end_addr", 32'(end_addr), 32'h0404);

    // Window check
    ack_delay = 0;
    tick();
    expect_wr(16'h3FFE, 8'h11);
    expect_wr(16'h3FFF, 8'h22);
    expect_fix(16'h4000);
    start_load(8'h41);
    send_byte(0, 8'hFE);
    send_byte(1, 8'h3F);
    send_byte(2, 8'h11);
    send_byte(3, 8'h22);
    send_byte(4, 8'h33);
    send_byte(5, 8'h44);
    ioctl_download = 1'b0;
    wait_done();
    check("win_error", 32'(error), 32'b001);
    check("win_load_addr", 32'(load_addr), 32'h3FFE);
    check("win_end_addr", 32'(end_addr), 32'h4000);

    // Short file
    tick();
    clear_counts();
    start_load(8'h41);
    send_byte(0, 8'h01);
    ioctl_download = 1'b0;
    wait_done();
    check("short_error", 32'(error), 32'b100);
    check("short_we_cycles", 32'(we_cycles), 32'd0);

    // Wrong index: nothing changes
    tick();
    clear_counts();
    start_load(8'h01);
    send_byte(0, 8'h01);
    send_byte(1, 8'h04);
    send_byte(2, 8'hAA);
    send_byte(3, 8'hBB);
    send_byte(4, 8'hCC);
    ioctl_download = 1'b0;
    repeat (5) tick();
    check("idx_we_cycles", 32'(we_cycles), 32'd0);
    check("idx_busy_cycles", 32'(busy_cycles), 32'd0);
    check("idx_done", 32'(done), 32'd1);
    check("idx_error", 32'(error), 32'b100);
    check("idx_load_addr", 32'(load_addr), 32'h0001);
    check("idx_end_addr", 32'(end_addr), 32'h0000);

    // Reset during the pending write of the second payload byte
    ack_delay = 5;
    expect_wr(16'h0401, 8'hAA);
    start_load(8'h41);
    send_byte(0, 8'h01);
    send_byte(1, 8'h04);
    send_byte(2, 8'hAA);
    send_byte(3, 8'hBB);
    tick();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_dma_we", 32'(dma_we), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Fresh load after the reset
    ack_delay = 0;
    repeat (2) tick();
    expect_wr(16'h0401, 8'hAA);
    expect_wr(16'h0402, 8'hBB);
    expect_wr(16'h0403, 8'hCC);
    expect_fix(16'h0404);
    start_load(8'h41);
    send_byte(0, 8'h01);
    send_byte(1, 8'h04);
    send_byte(2, 8'hAA);
    send_byte(3, 8'hBB);
    send_byte(4, 8'hCC);
    ioctl_download = 1'b0;
    wait_done();
    check("fresh_error", 32'(error), 32'd0);
    check("fresh_load_addr", 32'(load_addr), 32'h0401);
    check("fresh_end_addr", 32'(end_addr), 32'h0404);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
